rv32_inst_encoder: RTL and testbench
====================================

# rv32_inst_encoder

Pipelined RV32I instruction encoder: the inverse of the immediate generator. It accepts a decoded instruction (format, opcode, register fields, function fields and a full 32-bit immediate), packs it into the 32-bit instruction word and checks that the immediate fits the format. Each word is tagged with a sequential instruction-memory byte address. It sits between the debug/boot loader path and instruction memory, and a valid/ready handshake with a 2-entry output buffer decouples the two sides.

## Interface
Parameters:
- `ERR_CNT_W`, default 16: width of the saturating error counter.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous clear of the output buffer.
- `addr_load`  in  1  load the address counter from `addr_base`.
- `addr_base`  in  32  new base byte address; bits [1:0] are ignored and treated as 0.
- `in_valid`  in  1  input instruction is valid.
- `in_ready`  out  1  encoder can accept an input.
- `fmt`  in  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
- `opcode`  in  7  opcode field.
- `rd`, `rs1`, `rs2`  in  5 each  register fields.
- `funct3`  in  3  funct3 field.
- `funct7`  in  7  funct7 field.
- `imm`  in  32  full-width immediate (sign-extended value).
- `out_valid`  out  1  output buffer head is valid.
- `out_ready`  in  1  consumer accepts the head.
- `out_inst`  out  32  encoded instruction word.
- `out_addr`  out  32  byte address tag for the word.
- `out_err`  out  1  immediate range/alignment error, or illegal format.
- `err_cnt`  out  ERR_CNT_W  count of pushed entries with err=1; saturates at all-ones.

## Operation
- Push occurs when `in_valid && in_ready`. Encoding is combinational from the inputs; the result, its address tag and its error flag are written into a 2-entry FIFO.
- Pop occurs when `out_valid && out_ready`.
- Encoding, with opcode always in [6:0]:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
- Error rules:
  - I/S: error unless imm[31:11] is all equal.
  - B: error unless imm[31:12] is all equal and imm[0]=0.
  - J: error unless imm[31:20] is all equal and imm[0]=0.
  - U: error unless imm[11:0]=0.
  - R: never an error; `imm` is ignored.
- On a range/alignment error the word is still encoded from the truncated fields.
- Illegal `fmt` (6 or 7): `out_inst` = 32'h0000_0013 (NOP) and err=1.
- Address counter:
  - Each push tags the entry with the current address, then the counter advances by 4.
  - Wraps from 0xFFFF_FFFC to 0.
  - `addr_load` alone sets counter = {addr_base[31:2], 2'b00}.
  - `addr_load` together with a push: the entry is tagged with the new base, and the counter becomes base+4.
- `err_cnt` increments by 1 on each push with err=1 and holds at its maximum.
- `flush` empties the FIFO in the cycle it is high. A push in that cycle is discarded: the address counter does not advance and `err_cnt` does not change. `addr_load` is still honoured during flush.

## Timing
- Reset values: FIFO empty, `out_valid`=0, `out_inst`=0, `out_addr`=0, `out_err`=0, address counter=0, `err_cnt`=0, `in_ready`=1.
- Latency: a word pushed at edge N is visible on `out_*` with `out_valid`=1 after edge N, i.e. one cycle.
- `in_ready` = (FIFO occupancy < 2). It is registered-state-only, with no combinational path from `out_ready`.
- When the FIFO is full, a same-cycle pop does not allow a push.
- Push and pop in the same cycle at occupancy 1: occupancy stays 1, and the new entry becomes head after the edge.
- Output is ordered FIFO. `out_*` hold stable while `out_valid && !out_ready`.
- Asserting `rst_n`=0 mid-stream clears everything immediately (asynchronously). Entries in flight are lost.

## Test plan
- I-format, opcode 0x13, rd=1, rs1=0, funct3=0, imm=0xFFFF_FFFF -> `out_inst`=0xFFF0_0093, err=0, `out_addr`=0, with `out_valid` one cycle after the push.
- S-format sw (opcode 0x23, funct3=2, rs1=1, rs2=2, imm=8) -> 0x0020_A423. B-format beq (opcode 0x63, rs1=rs2=0, imm=0xFFFF_FFFC) -> 0xFE00_0EE3. Address tags are 0 and 4.
- J-format jal (rd=1, imm=0x800) -> 0x0010_00EF. U-format lui (rd=5, imm=0x1234_5000) -> 0x1234_52B7.
- Errors:
  - I imm=0x800 -> err=1.
  - B imm=3 -> err=1.
  - U imm=0x1 -> err=1.
  - fmt=7 -> 0x0000_0013 with err=1.
  - `err_cnt`=4 after these four pushes; preload near max to confirm it saturates.
- Backpressure: `out_ready`=0, three back-to-back pushes -> `in_ready` drops after 2 accepted and the third is held. Then raise `out_ready` -> words appear in order, `in_ready` reasserts, and no word is lost or duplicated.
- `addr_load` with base 0xFFFF_FFFE and a simultaneous push -> tag 0xFFFF_FFFC, the next push is tagged 0. `flush` with a simultaneous push -> FIFO empty, counter unchanged. `rst_n` low mid-stream -> all outputs return to their reset values.

Source files
------------

// File: rtl/rv32_inst_encoder.sv
// RV32I instruction encoder: packs decoded fields into a 32-bit word, flags immediates
// that do not fit the format, and queues word + address tag in a 2-entry output FIFO.
module rv32_inst_encoder #(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 addr_load,
    input  logic [31:0]          addr_base,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           fmt,
    input  logic [6:0]           opcode,
    input  logic [4:0]           rd,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic [31:0]          imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_inst,
    output logic [31:0]          out_addr,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic [31:0] enc_inst;
    logic        enc_err;

    // A sign-extended immediate fits when all of its upper bits match the top kept bit.
    always_comb begin
        enc_inst = NOP;
        enc_err  = 1'b1;
        case (fmt)
            FMT_R: begin
                enc_inst = {funct7, rs2, rs1, funct3, rd, opcode};
                enc_err  = 1'b0;
            end
            FMT_I: begin
                enc_inst = {imm[11:0], rs1, funct3, rd, opcode};
                enc_err  = !((&imm[31:11]) || !(|imm[31:11]));
            end
            FMT_S: begin
                enc_inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                enc_err  = !((&imm[31:11]) || !(|imm[31:11]));
            end
            FMT_B: begin
                enc_inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                enc_err  = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
            end
            FMT_U: begin
                enc_inst = {imm[31:12], rd, opcode};
                enc_err  = |imm[11:0];
            end
            FMT_J: begin
                enc_inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                enc_err  = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
            end
            default: begin
                enc_inst = NOP;
                enc_err  = 1'b1;
            end
        endcase
    end

    logic [64:0] mem [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;
    logic [31:0] addr_cnt;
    logic [31:0] tag_addr;
    logic        push;
    logic        pop;
    logic        unused_ok;

    assign unused_ok = ^addr_base[1:0];
    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign tag_addr  = addr_load ? {addr_base[31:2], 2'b00} : addr_cnt;

    assign out_inst  = mem[rd_ptr][64:33];
    assign out_addr  = mem[rd_ptr][32:1];
    assign out_err   = mem[rd_ptr][0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0]   <= '0;
            mem[1]   <= '0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            count    <= 2'd0;
            addr_cnt <= 32'd0;
            err_cnt  <= '0;
        end else if (flush) begin
            // A push coincident with flush is dropped; only the base load survives.
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            if (addr_load) begin
                addr_cnt <= tag_addr;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= {enc_inst, tag_addr, enc_err};
                wr_ptr      <= ~wr_ptr;
                addr_cnt    <= tag_addr + 32'd4;
                if (enc_err && (err_cnt != '1)) begin
                    err_cnt <= err_cnt + ERR_CNT_W'(1);
                end
            end else if (addr_load) begin
                addr_cnt <= tag_addr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_rv32_inst_encoder.sv
// Self-checking bench: directed spec vectors plus randomized traffic against a queue-based model.
module tb_rv32_inst_encoder;
    localparam int ERR_W   = 4;
    localparam int ERR_MAX = (1 << ERR_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n, flush, addr_load, in_valid, in_ready, out_valid, out_ready, out_err;
    logic [31:0]      addr_base, imm, out_inst, out_addr;
    logic [2:0]       fmt, funct3;
    logic [6:0]       opcode, funct7;
    logic [4:0]       rd, rs1, rs2;
    logic [ERR_W-1:0] err_cnt;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        err;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_addr;
    int          m_err;
    bit          last_push;
    int          n_vec = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    rv32_inst_encoder #(.ERR_CNT_W(ERR_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .addr_load(addr_load), .addr_base(addr_base),
        .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .opcode(opcode), .rd(rd),
        .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_addr(out_addr), .out_err(out_err), .err_cnt(err_cnt)
    );

    // Reference encoding by shifting fields into place; range checks as signed intervals.
    function automatic void ref_enc(output logic [31:0] w, output logic e);
        int signed si;
        logic [31:0] im;
        logic [31:0] base;
        im   = imm;
        si   = $signed(imm);
        base = (32'(funct3) << 12) | (32'(rs1) << 15) | 32'(opcode);
        case (fmt)
            3'd0: begin
                w = (32'(funct7) << 25) | (32'(rs2) << 20) | base | (32'(rd) << 7);
                e = 1'b0;
            end
            3'd1: begin
                w = ((im & 32'hFFF) << 20) | base | (32'(rd) << 7);
                e = !(si >= -2048 && si <= 2047);
            end
            3'd2: begin
                w = (((im >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | base | ((im & 32'h1F) << 7);
                e = !(si >= -2048 && si <= 2047);
            end
            3'd3: begin
                w = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | (32'(rs2) << 20)
                    | base | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7);
                e = !(si >= -4096 && si <= 4095) || (im % 2 != 0);
            end
            3'd4: begin
                w = (im & 32'hFFFF_F000) | (32'(rd) << 7) | 32'(opcode);
                e = (im & 32'hFFF) != 0;
            end
            3'd5: begin
                w = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                    | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12)
                    | (32'(rd) << 7) | 32'(opcode);
                e = !(si >= -1048576 && si <= 1048575) || (im % 2 != 0);
            end
            default: begin
                w = 32'h0000_0013;
                e = 1'b1;
            end
        endcase
    endfunction

    // Advance the model by one clock using the inputs currently driven, then clock the DUT.
    task automatic tick();
        ent_t        en;
        logic [31:0] tag;
        bit          pop, push;
        pop  = (q.size() > 0) && out_ready;
        push = in_valid && (q.size() < 2);
        last_push = 1'b0;
        tag  = addr_load ? {addr_base[31:2], 2'b00} : m_addr;
        if (flush) begin
            q.delete();
            if (addr_load) m_addr = tag;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                ref_enc(en.inst, en.err);
                en.addr = tag;
                q.push_back(en);
                m_addr = tag + 32'd4;
                if (en.err && m_err < ERR_MAX) m_err++;
                last_push = 1'b1;
            end else if (addr_load) begin
                m_addr = tag;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_inst(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                            input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                            input logic [31:0] im);
        fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = 7'h00; imm = im;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 0; addr_load = 0; addr_base = 0; in_valid = 0; out_ready = 0;
        set_inst(3'd0, 7'h33, 0, 0, 0, 0, 0);
        q.delete(); m_addr = 0; m_err = 0;
        #7;
        n_vec++;
        if (out_valid !== 1'b0 || out_inst !== 32'h0 || out_addr !== 32'h0 || out_err !== 1'b0
            || err_cnt !== '0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset: valid=%b inst=%h addr=%h err=%b cnt=%0d rdy=%b, want 0,0,0,0,0,1",
                     out_valid, out_inst, out_addr, out_err, err_cnt, in_ready);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [31:0] want [4] = '{32'h0020_A423, 32'hFE00_0EE3, 32'h0010_00EF, 32'h1234_52B7};
        logic [31:0] wadr [4] = '{32'd0, 32'd4, 32'd8, 32'd12};
        out_ready = 1'b1; in_valid = 1'b1;
        set_inst(3'd1, 7'h13, 1, 0, 0, 0, 32'hFFFF_FFFF);
        tick();
        n_vec++;
        if (out_valid !== 1'b1 || out_inst !== 32'hFFF0_0093 || out_err !== 1'b0 || out_addr !== 0) begin
            n_bad++;
            $display("FAIL addi: valid=%b inst=%h err=%b addr=%h, want 1 fff00093 0 0",
                     out_valid, out_inst, out_err, out_addr);
        end
        for (int i = 0; i < 4; i++) begin
            addr_load = (i == 0); addr_base = 32'h0;
            case (i)
                0: set_inst(3'd2, 7'h23, 0, 1, 2, 3'd2, 32'd8);
                1: set_inst(3'd3, 7'h63, 0, 0, 0, 3'd0, 32'hFFFF_FFFC);
                2: set_inst(3'd5, 7'h6F, 1, 0, 0, 3'd0, 32'h800);
                default: set_inst(3'd4, 7'h37, 5, 0, 0, 3'd0, 32'h1234_5000);
            endcase
            tick();
            n_vec++;
            if (out_valid !== 1'b1 || out_inst !== want[i] || out_addr !== wadr[i] || out_err !== 1'b0) begin
                n_bad++;
                $display("FAIL directed%0d: valid=%b inst=%h addr=%h err=%b, want 1 %h %h 0",
                         i, out_valid, out_inst, out_addr, out_err, want[i], wadr[i]);
            end
        end
        addr_load = 0; in_valid = 0;
        tick(); tick();
    endtask

    task automatic test_errors();
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 4 + 14; i++) begin
            case (i)
                0: set_inst(3'd1, 7'h13, 1, 0, 0, 0, 32'h800);
                1: set_inst(3'd3, 7'h63, 0, 1, 2, 0, 32'd3);
                2: set_inst(3'd4, 7'h37, 3, 0, 0, 0, 32'h1);
                default: set_inst(3'd7, 7'h33, 4, 5, 6, 1, 32'h0);
            endcase
            tick();
            n_vec++;
            if (out_valid !== 1'b1 || out_err !== 1'b1 || out_inst !== q[0].inst || err_cnt !== ERR_W'(m_err)) begin
                n_bad++;
                $display("FAIL err%0d: valid=%b err=%b inst=%h cnt=%0d, want 1 1 %h %0d",
                         i, out_valid, out_err, out_inst, err_cnt, q[0].inst, m_err);
            end
            if (i == 3) begin
                n_vec++;
                if (out_inst !== 32'h0000_0013 || err_cnt !== ERR_W'(4)) begin
                    n_bad++;
                    $display("FAIL err_count4: inst=%h cnt=%0d, want 00000013 4", out_inst, err_cnt);
                end
            end
        end
        n_vec++;
        if (err_cnt !== ERR_W'(ERR_MAX)) begin
            n_bad++;
            $display("FAIL err_saturate: cnt=%0d, want %0d", err_cnt, ERR_MAX);
        end
        in_valid = 0;
        tick(); tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] got[$];
        logic [31:0] exp_w[$];
        logic [31:0] w;
        logic        e;
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_inst(3'd0, 7'h33, 5'(i + 1), 5'(i + 2), 5'(i + 3), 3'(i), 32'h0);
            funct7 = 7'h20;
            ref_enc(w, e);
            exp_w.push_back(w);
            tick();
            n_vec++;
            if (in_ready !== (i == 0) || out_inst !== exp_w[0]) begin
                n_bad++;
                $display("FAIL backpressure%0d: in_ready=%b head=%h, want %b %h",
                         i, in_ready, out_inst, (i == 0), exp_w[0]);
            end
        end
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (out_valid) got.push_back(out_inst);
            tick();
            if (last_push) in_valid = 1'b0;
        end
        n_vec++;
        if (got.size() != 3 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL drain_count: words=%0d in_ready=%b, want 3 1", got.size(), in_ready);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_vec++;
                if (got[i] !== exp_w[i]) begin
                    n_bad++;
                    $display("FAIL drain_order%0d: got=%h want=%h", i, got[i], exp_w[i]);
                end
            end
        end
    endtask

    task automatic test_addr_load();
        out_ready = 1'b1; in_valid = 1'b1; addr_load = 1'b1; addr_base = 32'hFFFF_FFFE;
        set_inst(3'd1, 7'h13, 2, 3, 0, 0, 32'd5);
        tick();
        n_vec++;
        if (out_addr !== 32'hFFFF_FFFC || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL addr_load: addr=%h valid=%b, want fffffffc 1", out_addr, out_valid);
        end
        addr_load = 1'b0;
        tick();
        n_vec++;
        if (out_addr !== 32'h0) begin
            n_bad++;
            $display("FAIL addr_wrap: addr=%h, want 00000000", out_addr);
        end
        in_valid = 0;
        tick();
    endtask

    task automatic test_flush();
        logic [31:0] saved;
        out_ready = 1'b0; in_valid = 1'b1;
        set_inst(3'd0, 7'h33, 1, 1, 1, 0, 0);
        tick();
        saved = m_addr;
        flush = 1'b1;
        set_inst(3'd7, 7'h00, 0, 0, 0, 0, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_cnt !== ERR_W'(ERR_MAX)) begin
            n_bad++;
            $display("FAIL flush: valid=%b in_ready=%b cnt=%0d, want 0 1 %0d",
                     out_valid, in_ready, err_cnt, ERR_MAX);
        end
        in_valid = 1'b1;
        set_inst(3'd0, 7'h33, 2, 2, 2, 0, 0);
        tick();
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b1 || out_addr !== saved) begin
            n_bad++;
            $display("FAIL flush_addr: valid=%b addr=%h, want 1 %h", out_valid, out_addr, saved);
        end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic [31:0] r;
        for (int c = 0; c < 600; c++) begin
            r = $urandom;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 40) == 0);
            addr_load = ($urandom_range(0, 25) == 0);
            addr_base = $urandom;
            set_inst(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
                     5'($urandom), 3'($urandom), 32'h0);
            funct7 = 7'($urandom);
            case ($urandom_range(0, 3))
                0: imm = $urandom;
                1: imm = {{19{r[12]}}, r[12:0]};
                2: imm = r & 32'hFFFF_F000;
                default: imm = {{11{r[20]}}, r[20:0]};
            endcase
            tick();
            n_vec++;
            if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2) || err_cnt !== ERR_W'(m_err)) begin
                n_bad++;
                $display("FAIL rand_ctrl%0d: valid=%b in_ready=%b cnt=%0d, want %b %b %0d",
                         c, out_valid, in_ready, err_cnt, q.size() > 0, q.size() < 2, m_err);
            end else if (q.size() > 0) begin
                n_vec++;
                if (out_inst !== q[0].inst || out_addr !== q[0].addr || out_err !== q[0].err) begin
                    n_bad++;
                    $display("FAIL rand_data%0d: inst=%h addr=%h err=%b, want %h %h %b",
                             c, out_inst, out_addr, out_err, q[0].inst, q[0].addr, q[0].err);
                end
            end
        end
        flush = 0; addr_load = 0; in_valid = 0;
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        set_inst(3'd5, 7'h6F, 1, 0, 0, 0, 32'h7FE);
        tick(); tick();
        #3 rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || out_inst !== 32'h0 || out_addr !== 32'h0 || out_err !== 1'b0
            || err_cnt !== '0 || in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL async_reset: valid=%b inst=%h addr=%h err=%b cnt=%0d rdy=%b, want 0,0,0,0,0,1",
                     out_valid, out_inst, out_addr, out_err, err_cnt, in_ready);
        end
        q.delete(); m_addr = 0; m_err = 0;
        in_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1; out_ready = 1'b1;
        set_inst(3'd4, 7'h17, 7, 0, 0, 0, 32'hABCD_E000);
        tick();
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b1 || out_addr !== 32'h0 || out_inst !== q[0].inst) begin
            n_bad++;
            $display("FAIL post_reset: valid=%b addr=%h inst=%h, want 1 00000000 %h",
                     out_valid, out_addr, out_inst, q[0].inst);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_errors();
        test_back_to_back();
        test_addr_load();
        test_flush();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
